// File: rtl/bitonic_sort_ctrl_if.sv
// Handshake bundle for the iterative 4-element bitonic sorter.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
interface bitonic_sort_ctrl_if #(
   parameter int W = 8
);
   logic [4*W-1:0] data_in;
   logic           in_valid;
   logic           in_ready;
   logic [4*W-1:0] data_out;
   logic           out_valid;
   logic           out_ready;
   logic           busy;
   logic [2:0]     step;

   // Producer/consumer side: drives the inputs and observes the results.
   modport master (
      output data_in, in_valid, out_ready,
      input  in_ready, data_out, out_valid, busy, step
   );

   // Sorter side.
   modport slave (
      input  data_in, in_valid, out_ready,
      output in_ready, data_out, out_valid, busy, step
   );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Sorts four W-bit unsigned elements with one shared compare-exchange unit stepped through a 4-input bitonic network.
// Latency: accept at edge T, steps at T+1..T+6, out_valid high after T+6; one sort per 8 cycles at best.
// Backpressure: result and out_valid held while out_ready=0; in_ready low from accept until the result retires.
module bitonic_sort_ctrl #(
   parameter int W          = 8,
   parameter bit DESCENDING = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   bitonic_sort_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SORT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q;
   logic [2:0]     step_q;
   logic [W-1:0]   e_q [4];
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;

   logic [1:0]     cx_i;
   logic [1:0]     cx_j;
   logic           cx_desc;
   logic [W-1:0]   cx_a;
   logic [W-1:0]   cx_b;
   logic           cx_swap;
   logic [W-1:0]   e_d [4];

   // Compare-exchange for the current step: pick the pair and direction, swap if out of order.
   always_comb begin
      cx_i    = 2'd0;
      cx_j    = 2'd1;
      cx_desc = 1'b0;
      case (step_q)
         3'd0: begin cx_i = 2'd0; cx_j = 2'd1; cx_desc = 1'b0; end
         3'd1: begin cx_i = 2'd2; cx_j = 2'd3; cx_desc = 1'b1; end
         3'd2: begin cx_i = 2'd0; cx_j = 2'd2; cx_desc = 1'b0; end
         3'd3: begin cx_i = 2'd1; cx_j = 2'd3; cx_desc = 1'b0; end
         3'd4: begin cx_i = 2'd0; cx_j = 2'd1; cx_desc = 1'b0; end
         3'd5: begin cx_i = 2'd2; cx_j = 2'd3; cx_desc = 1'b0; end
         default: begin cx_i = 2'd0; cx_j = 2'd1; cx_desc = 1'b0; end
      endcase
      cx_a = e_q[cx_i];
      cx_b = e_q[cx_j];
      // A descending build flips every direction; equal values never swap.
      if (cx_desc ^ DESCENDING) begin
         cx_swap = (cx_a < cx_b);
      end else begin
         cx_swap = (cx_a > cx_b);
      end
      e_d = e_q;
      if (cx_swap) begin
         e_d[cx_i] = cx_b;
         e_d[cx_j] = cx_a;
      end
   end

   // Control FSM with registered handshake/status outputs and the element array.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         step_q      <= 3'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            e_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < 4; i++) begin
                     e_q[i] <= bus.data_in[i*W +: W];
                  end
                  step_q     <= 3'd0;
                  state_q    <= S_SORT;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_SORT: begin
               e_q <= e_d;
               if (step_q == 3'd5) begin
                  step_q      <= 3'd0;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  step_q <= step_q + 3'd1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               step_q      <= 3'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.step      = step_q;
   assign bus.data_out  = {e_q[3], e_q[2], e_q[1], e_q[0]};

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Bench for bitonic_sort_ctrl: ascending and descending instances driven in lockstep.
// Latency: checks accept-to-valid timing, busy duration and retire-to-ready timing.
// Backpressure: holds out_ready low while pulsing in_valid and checks the held result.
module tb_bitonic_sort_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] din;
   logic        ivld;
   logic        ordy;
   int          n_checks;
   int          n_pass;

   bitonic_sort_ctrl_if #(.W(8)) ia ();
   bitonic_sort_ctrl_if #(.W(8)) id ();

   assign ia.data_in   = din;
   assign ia.in_valid  = ivld;
   assign ia.out_ready = ordy;
   assign id.data_in   = din;
   assign id.in_valid  = ivld;
   assign id.out_ready = ordy;

   bitonic_sort_ctrl #(.W(8), .DESCENDING(1'b0)) u_asc (.clk(clk), .reset(reset), .bus(ia));
   bitonic_sort_ctrl #(.W(8), .DESCENDING(1'b1)) u_dsc (.clk(clk), .reset(reset), .bus(id));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain sort of the four unpacked elements, packed back in the requested order.
   function automatic logic [31:0] ref_sort(input logic [31:0] d, input bit desc);
      int v [4];
      int t;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) v[i] = int'(d[i*8 +: 8]);
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 3 - a; b++)
            if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
      r = '0;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = desc ? 8'(v[3-i]) : 8'(v[i]);
      return r;
   endfunction

   // Drives one transaction from IDLE with out_ready=1 and measures its timing.
   task automatic run_sort(input logic [31:0] d, output int lat, output int bcnt,
                           output logic [31:0] ra, output logic [31:0] rd, output int kr);
      lat = -1; bcnt = 0; kr = -1; ra = '0; rd = '0;
      ordy = 1'b1;
      din  = d;
      ivld = 1'b1;
      tick();
      ivld = 1'b0;
      din  = $urandom;
      if (ia.busy) bcnt++;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (ia.busy) bcnt++;
         if (ia.out_valid && lat < 0) begin
            lat = k; ra = ia.data_out; rd = id.data_out;
         end
         if (lat >= 0 && ia.in_ready) begin
            kr = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; din = 32'hA1B2C3D4; ivld = 1'b1; ordy = 1'b1;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (ia.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ia.in_ready); else n_pass++;
      n_checks++; if (ia.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ia.out_valid); else n_pass++;
      n_checks++; if (ia.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ia.busy); else n_pass++;
      n_checks++; if (ia.data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected 00000000", ia.data_out); else n_pass++;
      n_checks++; if (ia.step !== 3'd0) $display("FAIL reset_step: got %0d expected 0", ia.step); else n_pass++;
      tick(); tick();
      n_checks++; if (ia.busy !== 1'b0 || ia.in_ready !== 1'b1) $display("FAIL reset_no_accept: busy %b in_ready %b expected 0/1", ia.busy, ia.in_ready); else n_pass++;
      ivld = 1'b0;
      #3 reset = 1'b1;
      tick();
      n_checks++; if (ia.in_ready !== 1'b1 || ia.busy !== 1'b0) $display("FAIL reset_release_idle: in_ready %b busy %b expected 1/0", ia.in_ready, ia.busy); else n_pass++;
   endtask

   task automatic test_basic();
      int lat, bcnt, kr;
      logic [31:0] ra, rd;
      run_sort(32'h01020304, lat, bcnt, ra, rd, kr);
      n_checks++; if (bcnt !== 6) $display("FAIL basic_busy_cycles: got %0d expected 6", bcnt); else n_pass++;
      n_checks++; if (lat !== 6) $display("FAIL basic_latency: got %0d expected 6", lat); else n_pass++;
      n_checks++; if (ra !== 32'h04030201) $display("FAIL basic_asc_out: got %h expected 04030201", ra); else n_pass++;
      n_checks++; if (rd !== 32'h01020304) $display("FAIL basic_dsc_out: got %h expected 01020304", rd); else n_pass++;
      n_checks++; if (kr !== 7) $display("FAIL basic_ready_return: got %0d expected 7", kr); else n_pass++;
   endtask

   task automatic test_duplicates();
      int lat, bcnt, kr;
      logic [31:0] ra, rd;
      run_sort(32'hFF000505, lat, bcnt, ra, rd, kr);
      n_checks++; if (ra !== 32'hFF050500) $display("FAIL dup_asc_out: got %h expected FF050500", ra); else n_pass++;
      n_checks++; if (rd !== ref_sort(32'hFF000505, 1'b1)) $display("FAIL dup_dsc_out: got %h expected %h", rd, ref_sort(32'hFF000505, 1'b1)); else n_pass++;
      run_sort(32'h07070707, lat, bcnt, ra, rd, kr);
      n_checks++; if (ra !== 32'h07070707) $display("FAIL equal_asc_out: got %h expected 07070707", ra); else n_pass++;
      n_checks++; if (rd !== 32'h07070707) $display("FAIL equal_dsc_out: got %h expected 07070707", rd); else n_pass++;
   endtask

   task automatic test_backpressure();
      int got;
      logic [31:0] exp_a;
      exp_a = ref_sort(32'h9C3E7F11, 1'b0);
      ordy = 1'b0; din = 32'h9C3E7F11; ivld = 1'b1;
      tick();
      ivld = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         if (ia.out_valid) got = 1;
      end
      n_checks++; if (got !== 1) $display("FAIL bp_valid_timeout: got %0d expected 1", got); else n_pass++;
      for (int k = 0; k < 10; k++) begin
         din  = $urandom;
         ivld = k[0];
         tick();
         n_checks++; if (ia.out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b expected 1", ia.out_valid); else n_pass++;
         n_checks++; if (ia.data_out !== exp_a) $display("FAIL bp_hold_data: got %h expected %h", ia.data_out, exp_a); else n_pass++;
         n_checks++; if (ia.in_ready !== 1'b0 || ia.busy !== 1'b0) $display("FAIL bp_no_accept: in_ready %b busy %b expected 0/0", ia.in_ready, ia.busy); else n_pass++;
      end
      ivld = 1'b0; ordy = 1'b1;
      tick();
      n_checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) $display("FAIL bp_retire: out_valid %b in_ready %b expected 0/1", ia.out_valid, ia.in_ready); else n_pass++;
   endtask

   task automatic test_reset_mid_sort();
      int lat, bcnt, kr, seen, hit;
      logic [31:0] ra, rd;
      ordy = 1'b1; din = 32'h55AA3311; ivld = 1'b1;
      tick();
      ivld = 1'b0;
      hit = 0;
      for (int k = 0; k < 10 && !hit; k++) begin
         if (ia.step == 3'd3 && ia.busy) hit = 1; else tick();
      end
      n_checks++; if (hit !== 1) $display("FAIL mid_step3_timeout: got %0d expected 1", hit); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) $display("FAIL mid_reset_status: out_valid %b busy %b expected 0/0", ia.out_valid, ia.busy); else n_pass++;
      n_checks++; if (ia.in_ready !== 1'b1 || ia.data_out !== 32'h0) $display("FAIL mid_reset_idle: in_ready %b data %h expected 1/00000000", ia.in_ready, ia.data_out); else n_pass++;
      tick();
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ia.out_valid || ia.busy) seen++;
      end
      n_checks++; if (seen !== 0) $display("FAIL mid_no_valid_after: got %0d active cycles expected 0", seen); else n_pass++;
      run_sort(32'h0A141E28, lat, bcnt, ra, rd, kr);
      n_checks++; if (ra !== 32'h281E140A) $display("FAIL mid_next_sort: got %h expected 281E140A", ra); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] pat [2];
      int acc [8];
      logic [31:0] outa [8];
      logic [31:0] outd [8];
      int na, no, adv;
      pat[0] = 32'h01020304; pat[1] = 32'h80FF0001;
      na = 0; no = 0;
      ordy = 1'b1; ivld = 1'b1; din = pat[0];
      for (int c = 0; c < 40; c++) begin
         adv = (ia.in_ready && ivld) ? 1 : 0;
         if (adv) begin acc[na] = c; na++; end
         tick();
         if (adv) begin
            din = pat[na % 2];
            if (na >= 4) ivld = 1'b0;
         end
         if (ia.out_valid && no < 8) begin outa[no] = ia.data_out; outd[no] = id.data_out; no++; end
      end
      ivld = 1'b0;
      n_checks++; if (na !== 4 || no !== 4) $display("FAIL b2b_counts: accepts %0d outputs %0d expected 4/4", na, no); else n_pass++;
      for (int i = 0; i < 3 && i + 1 < na; i++) begin
         n_checks++; if (acc[i+1] - acc[i] !== 8) $display("FAIL b2b_spacing: got %0d expected 8", acc[i+1] - acc[i]); else n_pass++;
      end
      for (int i = 0; i < no && i < 4; i++) begin
         n_checks++; if (outa[i] !== ((i % 2 == 0) ? 32'h04030201 : 32'hFF800100)) $display("FAIL b2b_asc_out: idx %0d got %h", i, outa[i]); else n_pass++;
         n_checks++; if (outd[i] !== ref_sort(pat[i % 2], 1'b1)) $display("FAIL b2b_dsc_out: idx %0d got %h expected %h", i, outd[i], ref_sort(pat[i % 2], 1'b1)); else n_pass++;
      end
   endtask

   task automatic test_descending();
      int lat, bcnt, kr, bad;
      logic [31:0] ra, rd, v;
      run_sort(32'h04030201, lat, bcnt, ra, rd, kr);
      n_checks++; if (rd !== 32'h01020304) $display("FAIL dsc_fixed: got %h expected 01020304", rd); else n_pass++;
      n_checks++; if (ra !== 32'h04030201) $display("FAIL dsc_fixed_asc: got %h expected 04030201", ra); else n_pass++;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         v = $urandom;
         if (n % 8 == 0) v[15:8] = v[7:0];
         run_sort(v, lat, bcnt, ra, rd, kr);
         n_checks++;
         if (rd !== ref_sort(v, 1'b1) || lat !== 6) begin
            if (bad < 10) $display("FAIL rnd_dsc: in %h got %h expected %h latency %0d", v, rd, ref_sort(v, 1'b1), lat);
            bad++;
         end else n_pass++;
         n_checks++;
         if (ra !== ref_sort(v, 1'b0)) begin
            if (bad < 10) $display("FAIL rnd_asc: in %h got %h expected %h", v, ra, ref_sort(v, 1'b0));
            bad++;
         end else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_duplicates();
      test_backpressure();
      test_reset_mid_sort();
      test_back_to_back();
      test_descending();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
